addsub_seq: RTL and testbench
=============================

# addsub_seq

Parametrised, multi-cycle add / subtract-with-carry unit for the mantle arith library. It processes a WORDS×WIDTH-bit operand pair one WIDTH-bit slice per clock, chaining the carry through a register. This lets a wide operation run on a narrow carry chain. It generalises the fixed 2-bit combinational subtract-with-carry: selectable add/sub mode, valid/ready handshakes on both sides, and zero/overflow flags. Carry semantics match the existing arith blocks: SUB computes A + ~B + CIN, so CIN=1 means "no borrow in" and COUT=1 means "no borrow out".

## Interface
- WIDTH, default 8: slice width in bits; must be ≥1.
- WORDS, default 4: number of slices; total operand width N = WIDTH*WORDS; must be ≥1.

- CLKIN  in  1  sole clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- I_VALID  in  1  operands and mode are valid.
- I_READY  out  1  unit can accept; high only in IDLE.
- A  in  N  first operand.
- B  in  N  second operand.
- SUB  in  1  0 = A+B+CIN; 1 = A+~B+CIN.
- CIN  in  1  carry in (borrow-bar for SUB).
- O_VALID  out  1  result registers hold a finished result.
- O_READY  in  1  consumer accepts the result.
- O  out  N  sum/difference, modulo 2^N.
- COUT  out  1  carry out of bit N-1.
- Z  out  1  O == 0.
- V  out  1  signed overflow: carry into bit N-1 XOR carry out of bit N-1.

## Operation
- States:
  - IDLE: I_READY=1. On I_VALID, latch A, B (B inverted if SUB), CIN into the carry register, and set slice index k=0. Go to RUN.
  - RUN: compute slice k as {c, s} = A[k] + B'[k] + carry.
    - Write s into O[k].
    - Update carry ← c.
    - Update zero-accumulator ← zacc & (s==0).
    - On k==WORDS-1, also capture the carry into the slice MSB for V. Go to DONE.
    - Otherwise increment k.
  - DONE: O_VALID=1. On O_READY, go to IDLE.
- COUT = final carry register. Z = zero-accumulator. V computed from the captured top-slice carries.
- Inputs are sampled only on the accepting edge. Later changes to A/B/SUB/CIN have no effect on the operation in flight.
- O, COUT, Z and V are stable while O_VALID=1 and O_READY=0.
- Reset values: state=IDLE, I_READY=1 in the cycle after reset, O_VALID=0, O=0, COUT=0, Z=0, V=0, k=0.
- RESET has priority over every other event. Asserting it in RUN or DONE discards the operation; no partial result is ever flagged valid.
- WORDS=1: RUN lasts exactly one cycle.

## Timing
- Accept edge is t0 (I_VALID & I_READY). RUN occupies edges t0+1 … t0+WORDS. O_VALID is high from cycle t0+WORDS+1 onward.
- Result latency: WORDS+1 cycles from accept to O_VALID.
- Result handshake at edge t1 (O_VALID & O_READY): O_VALID drops and I_READY rises in cycle t1+1.
- Minimum issue interval: WORDS+2 cycles.
- No combinational path from I_VALID to I_READY, or from O_READY to O_VALID.
- The carry path per cycle is one WIDTH-bit ripple, which maps to an SB_CARRY chain on iCE40.

## Structure
- Shared arith package holds:
  - state encoding constants ST_IDLE, ST_RUN, ST_DONE;
  - MODE_ADD=0 and MODE_SUB=1;
  - the function computing ceil(log2(WORDS)) for the width of k.
- One sub-module, addsub_slice:
  - combinational WIDTH-bit adder with inputs I0, I1, CIN;
  - outputs O, COUT and MSB_CIN (carry into the slice MSB);
  - built as a chain of the existing FullAdder cells.
- Operand shift registers, or slice muxing by k, live in addsub_seq. Either form is acceptable if timing above holds.

## Test plan
All scenarios use WIDTH=8, WORDS=4 unless stated otherwise.

- ADD, A=0xFFFFFFFF, B=0x00000001, CIN=0 -> after 5 cycles: O=0x00000000, COUT=1, Z=1, V=0.
- SUB, A=5, B=3, CIN=1 -> O=0x00000002, COUT=1. SUB, A=3, B=5, CIN=1 -> O=0xFFFFFFFE, COUT=0, Z=0.
- ADD, A=0x7FFFFFFF, B=1, CIN=0 -> O=0x80000000, V=1, COUT=0. SUB, A=0x80000000, B=1, CIN=1 -> O=0x7FFFFFFF, V=1, COUT=1.
- Hold O_READY=0 for 6 cycles in DONE while toggling A/B/I_VALID -> O and flags unchanged, I_READY=0 throughout. Raise O_READY -> I_READY=1 next cycle.
- Assert RESET for one cycle after 2 RUN cycles -> next cycle IDLE, O_VALID=0, O=0. A following ADD of 1+1, CIN=0, yields O=2.
- WIDTH=2, WORDS=1, SUB=1: exhaustive A, B ∈ 0..3 and CIN ∈ {0,1} -> {COUT,O} equals A + (~B&3) + CIN for all 32 cases, with latency 2 cycles.

Source files
------------

// File: rtl/addsub_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : addsub_seq_pkg
// Purpose  : Shared definitions for the sequential add/subtract unit.
//            Holds the state encoding, the add/sub mode values and the helper
//            that sizes the slice index counter.
// Revision : 1.0 - initial release
// ============================================================================
package addsub_seq_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Operation select values for the SUB input
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // ceil(log2(words)), never less than 1 so the index register always exists
  function automatic int idx_width(input int words);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << w) < words) w = w + 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_seq_slice.sv
`default_nettype none
// ============================================================================
// Module   : addsub_slice
// Purpose  : Combinational WIDTH-bit ripple adder built from a chain of
//            full-adder cells. Also exposes the carry into the MSB so the
//            caller can derive signed overflow.
// Revision : 1.0 - initial release
// ============================================================================
module addsub_slice #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic             CIN,
  output logic [WIDTH-1:0] O,
  output logic             COUT,
  output logic             MSB_CIN
);

  // c[i] is the carry into bit i; c[WIDTH] leaves the slice
  logic [WIDTH:0] c;

  assign c[0] = CIN;

  // One full-adder cell per bit, rippled LSB to MSB
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign O[i]   = I0[i] ^ I1[i] ^ c[i];
    assign c[i+1] = (I0[i] & I1[i]) | (c[i] & (I0[i] ^ I1[i]));
  end

  assign COUT    = c[WIDTH];
  assign MSB_CIN = c[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/addsub_seq.sv
`default_nettype none
// ============================================================================
// Module   : addsub_seq
// Purpose  : Multi-cycle add / subtract-with-carry. A WORDS*WIDTH-bit operand
//            pair is processed one WIDTH-bit slice per clock with the carry
//            held in a register between slices. SUB computes A + ~B + CIN,
//            so CIN/COUT act as borrow-bar.
// Revision : 1.0 - initial release
// ============================================================================
module addsub_seq
  import addsub_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int WORDS = 4
) (
  input  logic                   CLKIN,
  input  logic                   RESET,
  input  logic                   I_VALID,
  output logic                   I_READY,
  input  logic [WIDTH*WORDS-1:0] A,
  input  logic [WIDTH*WORDS-1:0] B,
  input  logic                   SUB,
  input  logic                   CIN,
  output logic                   O_VALID,
  input  logic                   O_READY,
  output logic [WIDTH*WORDS-1:0] O,
  output logic                   COUT,
  output logic                   Z,
  output logic                   V
);

  localparam int              N      = WIDTH * WORDS;
  localparam int              KW     = idx_width(WORDS);
  localparam logic [KW-1:0]   K_LAST = KW'(WORDS - 1);

  state_t          state;
  logic [KW-1:0]   k;
  // Operand copies shift right one slice per RUN cycle so slice 0 is always
  // the one being worked on; B is stored already inverted for SUB.
  logic [N-1:0]    a_sh;
  logic [N-1:0]    b_sh;
  logic [N-1:0]    res;
  logic            carry;
  logic            zacc;
  logic            ovf;
  logic            in_rdy;
  logic            out_vld;

  logic [WIDTH-1:0] slice_sum;
  logic             slice_cout;
  logic             slice_msb_cin;

  addsub_slice #(
    .WIDTH (WIDTH)
  ) u_slice (
    .I0      (a_sh[WIDTH-1:0]),
    .I1      (b_sh[WIDTH-1:0]),
    .CIN     (carry),
    .O       (slice_sum),
    .COUT    (slice_cout),
    .MSB_CIN (slice_msb_cin)
  );

  // Controller: accept, step through slices, hold result until consumed
  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      state   <= ST_IDLE;
      k       <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      res     <= '0;
      carry   <= 1'b0;
      zacc    <= 1'b0;
      ovf     <= 1'b0;
      in_rdy  <= 1'b1;
      out_vld <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (I_VALID) begin
            a_sh   <= A;
            b_sh   <= (SUB == MODE_SUB) ? ~B : B;
            carry  <= CIN;
            k      <= '0;
            zacc   <= 1'b1;
            in_rdy <= 1'b0;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          for (int w = 0; w < WORDS; w++) begin
            if (k == KW'(w)) res[w*WIDTH +: WIDTH] <= slice_sum;
          end
          carry <= slice_cout;
          zacc  <= zacc & (slice_sum == '0);
          a_sh  <= a_sh >> WIDTH;
          b_sh  <= b_sh >> WIDTH;
          if (k == K_LAST) begin
            ovf     <= slice_msb_cin ^ slice_cout;
            out_vld <= 1'b1;
            state   <= ST_DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        ST_DONE: begin
          if (O_READY) begin
            out_vld <= 1'b0;
            in_rdy  <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: begin
          out_vld <= 1'b0;
          in_rdy  <= 1'b1;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign I_READY = in_rdy;
  assign O_VALID = out_vld;
  assign O       = res;
  assign COUT    = carry;
  assign Z       = zacc;
  assign V       = ovf;

endmodule
`default_nettype wire

// File: tb/tb_addsub_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_addsub_seq
// Purpose  : Directed self-checking bench for addsub_seq. One instance with
//            WIDTH=8/WORDS=4 and one with WIDTH=2/WORDS=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_addsub_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance: 8 x 4
  logic        iv, ir, sub, cin, ov, ordy, cout, z, v;
  logic [31:0] a, b, o;

  addsub_seq #(.WIDTH(8), .WORDS(4)) dut (
    .CLKIN(clk), .RESET(rst), .I_VALID(iv), .I_READY(ir), .A(a), .B(b),
    .SUB(sub), .CIN(cin), .O_VALID(ov), .O_READY(ordy), .O(o),
    .COUT(cout), .Z(z), .V(v)
  );

  // Small instance: 2 x 1
  logic       iv2, ir2, sub2, cin2, ov2, ordy2, cout2, z2, v2;
  logic [1:0] a2, b2, o2;

  addsub_seq #(.WIDTH(2), .WORDS(1)) dut2 (
    .CLKIN(clk), .RESET(rst), .I_VALID(iv2), .I_READY(ir2), .A(a2), .B(b2),
    .SUB(sub2), .CIN(cin2), .O_VALID(ov2), .O_READY(ordy2), .O(o2),
    .COUT(cout2), .Z(z2), .V(v2)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation on the main instance, check latency and result,
  // then consume it and check the return to IDLE.
  task automatic op(input string tag, input logic s, input logic [31:0] av,
                    input logic [31:0] bv, input logic c, input logic [31:0] eo,
                    input logic ec, input logic ez, input logic ev);
    int cnt;
    @(negedge clk);
    chk({tag, ":i_ready"}, ir, 1'b1);
    iv = 1'b1; sub = s; a = av; b = bv; cin = c;
    @(negedge clk);
    iv = 1'b0; a = ~av; b = ~bv; sub = ~s; cin = ~c;
    cnt = 1;
    while (!ov && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, ":latency"}, cnt, 5);
    chk({tag, ":o"}, o, eo);
    chk({tag, ":cout"}, cout, ec);
    chk({tag, ":z"}, z, ez);
    chk({tag, ":v"}, v, ev);
    ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
    chk({tag, ":ret_ready"}, ir, 1'b1);
    chk({tag, ":ret_valid"}, ov, 1'b0);
  endtask

  initial begin
    logic [31:0] held_o;
    logic [2:0]  held_f;
    int          cnt;
    logic [2:0]  exp3;

    rst = 1'b1;
    iv = 0; sub = 0; cin = 0; ordy = 0; a = '0; b = '0;
    iv2 = 0; sub2 = 0; cin2 = 0; ordy2 = 0; a2 = '0; b2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst:i_ready", ir, 1'b1);
    chk("rst:o_valid", ov, 1'b0);
    chk("rst:o", o, 32'h0);
    chk("rst:cout", cout, 1'b0);
    chk("rst:z", z, 1'b0);
    chk("rst:v", v, 1'b0);

    // Directed vectors
    op("add_wrap", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    op("sub_5_3",  1'b1, 32'd5, 32'd3, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
    op("sub_3_5",  1'b1, 32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    op("add_ovf",  1'b0, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    op("sub_ovf",  1'b1, 32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1);

    // Back-pressure: result must hold while O_READY stays low
    @(negedge clk);
    iv = 1'b1; sub = 1'b0; a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b1;
    @(negedge clk);
    iv = 1'b0;
    cnt = 1;
    while (!ov && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("hold:o_first", o, 32'h2345_678A);
    held_o = o;
    held_f = {cout, z, v};
    for (int i = 0; i < 6; i++) begin
      iv = ~iv; a = a ^ 32'hA5A5_A5A5; b = b + 32'h0101_0101;
      @(negedge clk);
      chk("hold:i_ready", ir, 1'b0);
      chk("hold:o_valid", ov, 1'b1);
      chk("hold:o", o, held_o);
      chk("hold:flags", {cout, z, v}, held_f);
    end
    iv = 1'b0;
    ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
    chk("hold:release_ready", ir, 1'b1);

    // Reset mid-RUN discards the operation
    iv = 1'b1; sub = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0102_0304; cin = 1'b0;
    @(negedge clk);
    iv = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst:i_ready", ir, 1'b1);
    chk("midrst:o_valid", ov, 1'b0);
    chk("midrst:o", o, 32'h0);
    repeat (6) begin
      @(negedge clk);
      chk("midrst:no_valid", ov, 1'b0);
    end
    op("after_rst", 1'b0, 32'd1, 32'd1, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0);

    // Small instance: exhaustive 2-bit subtract, single-slice latency
    for (int ai = 0; ai < 4; ai++) begin
      for (int bi = 0; bi < 4; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          exp3 = 3'(ai + ((~bi) & 3) + ci);
          @(negedge clk);
          iv2 = 1'b1; sub2 = 1'b1; a2 = 2'(ai); b2 = 2'(bi); cin2 = 1'(ci);
          @(negedge clk);
          iv2 = 1'b0; a2 = ~a2; b2 = ~b2;
          cnt = 1;
          while (!ov2 && cnt < 10) begin
            @(negedge clk);
            cnt++;
          end
          chk($sformatf("w1 a=%0d b=%0d c=%0d lat", ai, bi, ci), cnt, 2);
          chk($sformatf("w1 a=%0d b=%0d c=%0d res", ai, bi, ci), {cout2, o2}, exp3);
          ordy2 = 1'b1;
          @(negedge clk);
          ordy2 = 1'b0;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
